// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame decoder driving register file, ALU and TX FIFO
//
// Purpose:
//   Decodes 1-4 byte command frames from the UART receive path and sequences
//   register-file writes/reads and ALU operations. Read data and ALU results
//   are returned byte-wise into the UART TX FIFO. Protocol errors and response
//   timeouts raise a one-cycle registered err pulse; the FSM always recovers
//   to IDLE.
//
// Frames (first byte is the command):
//   0xAA addr data      register write
//   0xBB addr           register read, one response byte
//   0xCC A B fun        write A->reg0, B->reg1, run ALU, two response bytes
//   0xDD fun            run ALU on current operands, two response bytes
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   rx_data_i        received byte, qualified by rx_valid_i
//   rx_valid_i       one-cycle pulse per received byte
//   rf_rd_data_i     register-file read data
//   rf_rd_valid_i    read data valid pulse
//   alu_out_i        ALU result
//   alu_out_valid_i  ALU result valid pulse
//   tx_full_i        TX FIFO full
//   rf_addr_o        register-file address
//   rf_wr_en_o       register-file write strobe
//   rf_rd_en_o       register-file read strobe
//   rf_wr_data_o     register-file write data
//   alu_en_o         ALU start strobe
//   alu_fun_o        ALU function code
//   clk_gate_en_o    ALU clock-gate enable
//   tx_data_o        byte pushed into the TX FIFO
//   tx_valid_o       TX FIFO push
//   err_o            one-cycle registered error pulse

module uart_cmd_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rf_rd_data_i,
    input  logic              rf_rd_valid_i,
    input  logic [15:0]       alu_out_i,
    input  logic              alu_out_valid_i,
    input  logic              tx_full_i,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic              rf_wr_en_o,
    output logic              rf_rd_en_o,
    output logic [7:0]        rf_wr_data_o,
    output logic              alu_en_o,
    output logic [3:0]        alu_fun_o,
    output logic              clk_gate_en_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              err_o
);

    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;

    // Last count value of the wait window; the window is TIMEOUT cycles long
    // because the counter starts at 0 on the first waiting cycle.
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [4:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        OP_A,
        A_WR,
        OP_B,
        B_WR,
        ALU_FUN,
        ALU_EXEC,
        ALU_WAIT,
        TX_RD,
        TX_LO,
        TX_HI
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;      // write data, also holds operand A/B
    logic [3:0]        fun_q;
    logic [15:0]       result_q;    // read byte in [7:0], or full ALU result
    logic [7:0]        wait_cnt_q;
    logic              err_q;

    logic              capture_state;
    logic              tx_fire;

    // States that consume a received byte; a byte arriving anywhere else is
    // dropped and flagged.
    always_comb begin
        capture_state = 1'b0;
        case (state_q)
            IDLE, WR_ADDR, WR_DATA, RD_ADDR,
            OP_A, OP_B, ALU_FUN:             capture_state = 1'b1;
            default:                         capture_state = 1'b0;
        endcase
    end

    // Moore-decoded strobes; all data outputs fall back to zero outside the
    // states that own them.
    always_comb begin
        rf_addr_o     = '0;
        rf_wr_en_o    = 1'b0;
        rf_rd_en_o    = 1'b0;
        rf_wr_data_o  = 8'h00;
        alu_en_o      = 1'b0;
        alu_fun_o     = 4'h0;
        clk_gate_en_o = 1'b0;
        tx_data_o     = 8'h00;
        tx_valid_o    = 1'b0;
        case (state_q)
            WR_EXEC: begin
                rf_wr_en_o   = 1'b1;
                rf_addr_o    = addr_q;
                rf_wr_data_o = data_q;
            end
            A_WR: begin
                rf_wr_en_o   = 1'b1;
                rf_addr_o    = ADDR_W'(0);
                rf_wr_data_o = data_q;
            end
            B_WR: begin
                rf_wr_en_o   = 1'b1;
                rf_addr_o    = ADDR_W'(1);
                rf_wr_data_o = data_q;
            end
            RD_EXEC: begin
                rf_rd_en_o   = 1'b1;
                rf_addr_o    = addr_q;
            end
            ALU_EXEC: begin
                alu_en_o      = 1'b1;
                alu_fun_o     = fun_q;
                clk_gate_en_o = 1'b1;
            end
            ALU_WAIT: begin
                clk_gate_en_o = 1'b1;
            end
            TX_RD, TX_LO: begin
                tx_data_o  = result_q[7:0];
                tx_valid_o = ~tx_full_i;
            end
            TX_HI: begin
                tx_data_o  = result_q[15:8];
                tx_valid_o = ~tx_full_i;
            end
            default: ;
        endcase
        tx_fire = tx_valid_o;
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= 8'h00;
            fun_q      <= 4'h0;
            result_q   <= 16'h0000;
            wait_cnt_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rx_valid_i) begin
                        case (rx_data_i)
                            CMD_WR:     state_q <= WR_ADDR;
                            CMD_RD:     state_q <= RD_ADDR;
                            CMD_ALU_OP: state_q <= OP_A;
                            CMD_ALU:    state_q <= ALU_FUN;
                            default:    err_q   <= 1'b1;
                        endcase
                    end
                end

                WR_ADDR: begin
                    if (rx_valid_i) begin
                        addr_q  <= rx_data_i[ADDR_W-1:0];
                        state_q <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (rx_valid_i) begin
                        data_q  <= rx_data_i;
                        state_q <= WR_EXEC;
                    end
                end

                WR_EXEC: state_q <= IDLE;

                RD_ADDR: begin
                    if (rx_valid_i) begin
                        addr_q  <= rx_data_i[ADDR_W-1:0];
                        state_q <= RD_EXEC;
                    end
                end

                RD_EXEC: begin
                    wait_cnt_q <= 8'h00;
                    state_q    <= RD_WAIT;
                end

                // A valid pulse on the final waiting cycle still wins over
                // the timeout because it is tested first.
                RD_WAIT: begin
                    if (rf_rd_valid_i) begin
                        result_q <= {8'h00, rf_rd_data_i};
                        state_q  <= TX_RD;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                OP_A: begin
                    if (rx_valid_i) begin
                        data_q  <= rx_data_i;
                        state_q <= A_WR;
                    end
                end

                A_WR: state_q <= OP_B;

                OP_B: begin
                    if (rx_valid_i) begin
                        data_q  <= rx_data_i;
                        state_q <= B_WR;
                    end
                end

                B_WR: state_q <= ALU_FUN;

                ALU_FUN: begin
                    if (rx_valid_i) begin
                        fun_q   <= rx_data_i[3:0];
                        state_q <= ALU_EXEC;
                    end
                end

                ALU_EXEC: begin
                    wait_cnt_q <= 8'h00;
                    state_q    <= ALU_WAIT;
                end

                ALU_WAIT: begin
                    if (alu_out_valid_i) begin
                        result_q <= alu_out_i;
                        state_q  <= TX_LO;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                // TX states only move on an accepted push, so a full FIFO
                // simply stalls here with the byte held.
                TX_RD: if (tx_fire) state_q <= IDLE;
                TX_LO: if (tx_fire) state_q <= TX_HI;
                TX_HI: if (tx_fire) state_q <= IDLE;

                default: state_q <= IDLE;
            endcase

            // A byte arriving while the FSM is busy is discarded.
            if (rx_valid_i && !capture_state) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard testbench for uart_cmd_ctrl

module tb_uart_cmd_ctrl;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ALU = 2;
    localparam int K_TX  = 3;
    localparam int K_ERR = 4;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic        clk_i;
    logic        rst_n_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  rf_rd_data_i;
    logic        rf_rd_valid_i;
    logic [15:0] alu_out_i;
    logic        alu_out_valid_i;
    logic        tx_full_i;
    logic [3:0]  rf_addr_o;
    logic        rf_wr_en_o;
    logic        rf_rd_en_o;
    logic [7:0]  rf_wr_data_o;
    logic        alu_en_o;
    logic [3:0]  alu_fun_o;
    logic        clk_gate_en_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        err_o;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   cyc;
    int   c0;

    uart_cmd_ctrl #(.ADDR_W(4), .TIMEOUT(255)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .rx_data_i       (rx_data_i),
        .rx_valid_i      (rx_valid_i),
        .rf_rd_data_i    (rf_rd_data_i),
        .rf_rd_valid_i   (rf_rd_valid_i),
        .alu_out_i       (alu_out_i),
        .alu_out_valid_i (alu_out_valid_i),
        .tx_full_i       (tx_full_i),
        .rf_addr_o       (rf_addr_o),
        .rf_wr_en_o      (rf_wr_en_o),
        .rf_rd_en_o      (rf_rd_en_o),
        .rf_wr_data_o    (rf_wr_data_o),
        .alu_en_o        (alu_en_o),
        .alu_fun_o       (alu_fun_o),
        .clk_gate_en_o   (clk_gate_en_o),
        .tx_data_o       (tx_data_o),
        .tx_valid_o      (tx_valid_o),
        .err_o           (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] a, input logic [7:0] d, input int at);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe the DUT presents is matched against the next
    // queued expectation, including the cycle it is due in.
    task automatic mon_event(input int kind, input logic [7:0] a, input logic [7:0] d, input logic gate);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d a=%h d=%h cyc=%0d, expected none", kind, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a || e.d !== d || e.cyc != cyc ||
                (kind == K_ALU && gate !== 1'b1)) begin
                failures++;
                $display("FAIL event: got kind=%0d a=%h d=%h cyc=%0d gate=%b, expected kind=%0d a=%h d=%h cyc=%0d",
                         kind, a, d, cyc, gate, e.kind, e.a, e.d, e.cyc);
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (rf_wr_en_o) mon_event(K_WR, 8'(rf_addr_o), rf_wr_data_o, clk_gate_en_o);
            if (rf_rd_en_o) mon_event(K_RD, 8'(rf_addr_o), 8'h00, clk_gate_en_o);
            if (alu_en_o)   mon_event(K_ALU, 8'(alu_fun_o), 8'h00, clk_gate_en_o);
            if (tx_valid_o) mon_event(K_TX, 8'h00, tx_data_o, clk_gate_en_o);
            if (err_o)      mon_event(K_ERR, 8'h00, 8'h00, clk_gate_en_o);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Byte is sampled at the next edge; on return cyc is the cycle in which
    // a strobe caused by this byte appears.
    task automatic send(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        step();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic drain(input string name, input int n);
        repeat (n) step();
        chk(name, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},   16'(rf_wr_en_o),    16'd0);
        chk({tag, "_rd_en"},   16'(rf_rd_en_o),    16'd0);
        chk({tag, "_alu_en"},  16'(alu_en_o),      16'd0);
        chk({tag, "_gate"},    16'(clk_gate_en_o), 16'd0);
        chk({tag, "_tx_valid"},16'(tx_valid_o),    16'd0);
        chk({tag, "_err"},     16'(err_o),         16'd0);
        chk({tag, "_addr"},    16'(rf_addr_o),     16'd0);
        chk({tag, "_wr_data"}, 16'(rf_wr_data_o),  16'd0);
        chk({tag, "_fun"},     16'(alu_fun_o),     16'd0);
        chk({tag, "_tx_data"}, 16'(tx_data_o),     16'd0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n_i         = 1'b0;
        rx_data_i       = 8'h00;
        rx_valid_i      = 1'b0;
        rf_rd_data_i    = 8'h00;
        rf_rd_valid_i   = 1'b0;
        alu_out_i       = 16'h0000;
        alu_out_valid_i = 1'b0;
        tx_full_i       = 1'b0;

        step();
        step();
        chk_all_zero("reset");
        rst_n_i = 1'b1;
        step();

        // Write frame
        send(8'hAA); send(8'h05); send(8'h3C);
        expect_ev(K_WR, 8'h05, 8'h3C, cyc);
        drain("write_drain", 3);

        // Read frame, data two cycles after the strobe
        send(8'hBB); send(8'h07);
        expect_ev(K_RD, 8'h07, 8'h00, cyc);
        step(); step();
        rf_rd_data_i  = 8'h9E;
        rf_rd_valid_i = 1'b1;
        expect_ev(K_TX, 8'h00, 8'h9E, cyc + 1);
        step();
        rf_rd_valid_i = 1'b0;
        drain("read_drain", 3);

        // ALU frame with operands and a stalled high byte
        send(8'hCC);
        send(8'h12);
        expect_ev(K_WR, 8'h00, 8'h12, cyc);
        step();
        send(8'h34);
        expect_ev(K_WR, 8'h01, 8'h34, cyc);
        step();
        send(8'h02);
        expect_ev(K_ALU, 8'h02, 8'h00, cyc);
        step(); step();
        chk("alu_wait_gate", 16'(clk_gate_en_o), 16'd1);
        alu_out_i       = 16'h0048;
        alu_out_valid_i = 1'b1;
        expect_ev(K_TX, 8'h00, 8'h48, cyc + 1);
        step();
        alu_out_valid_i = 1'b0;
        step();
        tx_full_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_tx_valid", 16'(tx_valid_o), 16'd0);
            chk("stall_tx_data",  16'(tx_data_o),  16'h0000);
            step();
        end
        tx_full_i = 1'b0;
        expect_ev(K_TX, 8'h00, 8'h00, cyc);
        step();
        chk("alu_done_gate", 16'(clk_gate_en_o), 16'd0);
        drain("alu_drain", 3);

        // Illegal command byte
        send(8'h55);
        expect_ev(K_ERR, 8'h00, 8'h00, cyc);
        drain("bad_cmd_drain", 3);

        // Extra byte during RD_WAIT; read still completes
        send(8'hBB); send(8'h07);
        expect_ev(K_RD, 8'h07, 8'h00, cyc);
        step();
        send(8'h11);
        expect_ev(K_ERR, 8'h00, 8'h00, cyc);
        rf_rd_data_i  = 8'h3B;
        rf_rd_valid_i = 1'b1;
        expect_ev(K_TX, 8'h00, 8'h3B, cyc + 1);
        step();
        rf_rd_valid_i = 1'b0;
        drain("rx_in_wait_drain", 3);

        // Timeout: 255 waiting cycles, err in the following cycle
        send(8'hBB); send(8'h03);
        c0 = cyc;
        expect_ev(K_RD, 8'h03, 8'h00, c0);
        expect_ev(K_ERR, 8'h00, 8'h00, c0 + 256);
        wait_until(c0 + 258);
        send(8'hAA); send(8'h01); send(8'hFF);
        expect_ev(K_WR, 8'h01, 8'hFF, cyc);
        drain("timeout_drain", 3);

        // Valid on the last waiting cycle beats the timeout
        send(8'hBB); send(8'h03);
        c0 = cyc;
        expect_ev(K_RD, 8'h03, 8'h00, c0);
        wait_until(c0 + 255);
        rf_rd_data_i  = 8'h5A;
        rf_rd_valid_i = 1'b1;
        expect_ev(K_TX, 8'h00, 8'h5A, c0 + 256);
        step();
        rf_rd_valid_i = 1'b0;
        drain("coincide_drain", 4);

        // Asynchronous reset while waiting for the ALU
        send(8'hDD); send(8'h05);
        expect_ev(K_ALU, 8'h05, 8'h00, cyc);
        step(); step();
        chk("pre_reset_gate", 16'(clk_gate_en_o), 16'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        rst_n_i         = 1'b1;
        alu_out_i       = 16'hBEEF;
        alu_out_valid_i = 1'b1;
        step();
        alu_out_valid_i = 1'b0;
        drain("late_valid_drain", 3);

        send(8'hDD); send(8'h03);
        expect_ev(K_ALU, 8'h03, 8'h00, cyc);
        step();
        alu_out_i       = 16'h1234;
        alu_out_valid_i = 1'b1;
        expect_ev(K_TX, 8'h00, 8'h34, cyc + 1);
        expect_ev(K_TX, 8'h00, 8'h12, cyc + 2);
        step();
        alu_out_valid_i = 1'b0;
        drain("post_reset_drain", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
